// File: rtl/aipp_pkg.sv
// Shared AIPP definitions: link opcode, beat field positions, descriptor and FSM types.
// The far-end parser imports the same opcode and field constants.
package aipp_pkg;

  localparam logic [15:0] AIPP_OPCODE = 16'hBEFF;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 15;
  localparam int JOB_LSB  = 16;
  localparam int JOB_MSB  = 31;
  localparam int CLS_LSB  = 32;
  localparam int CLS_MSB  = 39;
  localparam int IDX_LSB  = 40;
  localparam int IDX_MSB  = 47;
  localparam int LEAD_LSB = 48;
  localparam int LEAD_MSB = 63;

  typedef struct packed {
    logic [15:0] job_id;
    logic [7:0]  pwr_class;
    logic [15:0] lead_ns;
  } aipp_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP
  } aipp_state_t;

  function automatic logic [63:0] aipp_beat(input aipp_desc_t d, input logic [7:0] idx);
    logic [63:0] b;
    b                    = '0;
    b[OPC_MSB:OPC_LSB]   = AIPP_OPCODE;
    b[JOB_MSB:JOB_LSB]   = d.job_id;
    b[CLS_MSB:CLS_LSB]   = d.pwr_class;
    b[IDX_MSB:IDX_LSB]   = idx;
    b[LEAD_MSB:LEAD_LSB] = d.lead_ns;
    return b;
  endfunction

endpackage

// File: rtl/aipp_header_tx_if.sv
// Scheduler request channel plus outgoing link beat for the AIPP header generator.
interface aipp_header_tx_if;
  logic        tx_en;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_job_id;
  logic [7:0]  req_pwr_class;
  logic [15:0] req_lead_ns;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        busy;
  logic        burst_done;

  modport master (
    output tx_en, req_valid, req_job_id, req_pwr_class, req_lead_ns,
    input  req_ready, tx_data, tx_valid, busy, burst_done
  );

  modport slave (
    input  tx_en, req_valid, req_job_id, req_pwr_class, req_lead_ns,
    output req_ready, tx_data, tx_valid, busy, burst_done
  );
endinterface

// File: rtl/aipp_req_fifo.sv
// Two-entry descriptor FIFO; occupancy clears asynchronously, storage is never reset.
module aipp_req_fifo
  import aipp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  aipp_desc_t wr_data,
  output aipp_desc_t rd_data,
  output logic       full,
  output logic       empty
);

  aipp_desc_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aipp_header_tx.sv
// AIPP heavy-job header generator: pops a queued descriptor, emits BEATS opcode-stamped
// beats back to back, then holds the link idle for GAP cycles so the far-end parser resets.
module aipp_header_tx
  import aipp_pkg::*;
#(
  parameter int BEATS = 9,
  parameter int GAP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  aipp_header_tx_if.slave   bus
);

  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);
  localparam logic [7:0] LAST_GAP  = 8'(GAP - 1);

  aipp_state_t state;
  logic [7:0]  beat_cnt;
  logic [7:0]  gap_cnt;
  aipp_desc_t  fifo_head;
  aipp_desc_t  hold_q;
  aipp_desc_t  req_desc;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  assign req_desc      = '{job_id: bus.req_job_id, pwr_class: bus.req_pwr_class,
                           lead_ns: bus.req_lead_ns};
  assign bus.req_ready = !fifo_full;
  assign pop           = (state == ST_IDLE) && !fifo_empty && bus.tx_en;

  aipp_req_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.req_valid),
    .pop     (pop),
    .wr_data (req_desc),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (pop) hold_q <= fifo_head;
  end

  // beat_cnt tracks the index of the beat currently on tx_data; beat 0 is built
  // straight from the FIFO head so it leaves on the cycle after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      beat_cnt       <= 8'd0;
      gap_cnt        <= 8'd0;
      bus.tx_data    <= '0;
      bus.tx_valid   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.burst_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state          <= ST_BURST;
            beat_cnt       <= 8'd0;
            bus.tx_data    <= aipp_beat(fifo_head, 8'd0);
            bus.tx_valid   <= 1'b1;
            bus.busy       <= 1'b1;
            bus.burst_done <= (LAST_BEAT == 8'd0);
          end
        end
        ST_BURST: begin
          if (beat_cnt == LAST_BEAT) begin
            state          <= ST_GAP;
            gap_cnt        <= 8'd0;
            bus.tx_data    <= '0;
            bus.tx_valid   <= 1'b0;
            bus.burst_done <= 1'b0;
          end else begin
            beat_cnt       <= beat_cnt + 8'd1;
            bus.tx_data    <= aipp_beat(hold_q, beat_cnt + 8'd1);
            bus.burst_done <= ((beat_cnt + 8'd1) == LAST_BEAT);
          end
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          bus.tx_data    <= '0;
          bus.tx_valid   <= 1'b0;
          bus.busy       <= 1'b0;
          bus.burst_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aipp_header_tx.sv
// Directed bench for aipp_header_tx: default and minimum-parameter instances side by side.
module tb_aipp_header_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  aipp_header_tx_if ifa ();
  aipp_header_tx_if ifb ();

  aipp_header_tx #(.BEATS(9), .GAP(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  aipp_header_tx #(.BEATS(1), .GAP(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Far-end 8-deep line parser: fires on the ninth consecutive opcode beat.
  int   pcnt = 0;
  logic trig = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pcnt <= 0;
    end else if (ifa.tx_valid && ifa.tx_data[15:0] == 16'hBEFF) begin
      if (pcnt < 255) pcnt <= pcnt + 1;
      if (pcnt >= 8) trig <= 1'b1;
    end else begin
      pcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [15:0] job, input logic [7:0] cls,
                                       input logic [15:0] lead, input logic [7:0] idx);
    return {lead, idx, cls, job, 16'hBEFF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] job, input logic [7:0] cls,
                         input logic [15:0] lead);
    ifa.req_valid     = v;
    ifa.req_job_id    = job;
    ifa.req_pwr_class = cls;
    ifa.req_lead_ns   = lead;
  endtask

  task automatic drive_b(input logic v, input logic [15:0] job, input logic [7:0] cls,
                         input logic [15:0] lead);
    ifb.req_valid     = v;
    ifb.req_job_id    = job;
    ifb.req_pwr_class = cls;
    ifb.req_lead_ns   = lead;
  endtask

  logic [15:0] job_t  [3];
  logic [7:0]  cls_t  [3];
  logic [15:0] lead_t [3];

  initial begin
    int nbeats;
    int zrun;
    int last_n;
    int exp_z;

    job_t[0] = 16'hA001; cls_t[0] = 8'h11; lead_t[0] = 16'h0100;
    job_t[1] = 16'hB002; cls_t[1] = 8'h22; lead_t[1] = 16'h0200;
    job_t[2] = 16'hC003; cls_t[2] = 8'h33; lead_t[2] = 16'h0300;

    ifa.tx_en = 1'b0;
    ifb.tx_en = 1'b1;
    drive_a(1'b0, 16'h0, 8'h0, 16'h0);
    drive_b(1'b0, 16'h0, 8'h0, 16'h0);

    // Reset values
    #12;
    chk("rst_tx_data",    ifa.tx_data,          64'h0);
    chk("rst_tx_valid",   64'(ifa.tx_valid),    64'h0);
    chk("rst_busy",       64'(ifa.busy),        64'h0);
    chk("rst_burst_done", 64'(ifa.burst_done),  64'h0);
    chk("rst_req_ready",  64'(ifa.req_ready),   64'h1);
    chk("rst_b_req_ready", 64'(ifb.req_ready),  64'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request
    ifa.tx_en = 1'b1;
    drive_a(1'b1, 16'h1234, 8'h05, 16'h00C8);
    tick();
    drive_a(1'b0, 16'h0, 8'h0, 16'h0);
    chk("single_t1_valid", 64'(ifa.tx_valid), 64'h0);
    tick();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("single_beat%0d", k), ifa.tx_data,
          beat(16'h1234, 8'h05, 16'h00C8, 8'(k)));
      chk($sformatf("single_valid%0d", k), 64'(ifa.tx_valid), 64'h1);
      chk($sformatf("single_done%0d", k), 64'(ifa.burst_done), 64'(k == 8));
      tick();
    end
    chk("single_gap1_valid", 64'(ifa.tx_valid), 64'h0);
    chk("single_gap1_data",  ifa.tx_data,       64'h0);
    chk("single_gap1_busy",  64'(ifa.busy),     64'h1);
    tick();
    chk("single_gap2_valid", 64'(ifa.tx_valid), 64'h0);
    chk("single_gap2_busy",  64'(ifa.busy),     64'h1);
    tick();
    chk("single_idle_busy",  64'(ifa.busy),     64'h0);
    chk("parser_trigger",    64'(trig),         64'h1);

    // Back-to-back: three pushes on consecutive cycles
    nbeats = 0;
    zrun   = 0;
    for (int n = 0; n < 45; n++) begin
      if (n < 3)  chk($sformatf("b2b_ready%0d", n), 64'(ifa.req_ready), 64'h1);
      if (n == 3) chk("b2b_ready_full", 64'(ifa.req_ready), 64'h0);
      if (ifa.tx_valid) begin
        if (nbeats < 27)
          chk($sformatf("b2b_beat%0d", nbeats), ifa.tx_data,
              beat(job_t[nbeats / 9], cls_t[nbeats / 9], lead_t[nbeats / 9], 8'(nbeats % 9)));
        if (nbeats > 0) begin
          exp_z = (nbeats % 9 == 0) ? 3 : 0;
          chk($sformatf("b2b_idle_before%0d", nbeats), 64'(zrun), 64'(exp_z));
        end
        nbeats++;
        zrun = 0;
      end else begin
        zrun++;
      end
      if (n < 3) drive_a(1'b1, job_t[n], cls_t[n], lead_t[n]);
      else       drive_a(1'b0, 16'h0, 8'h0, 16'h0);
      tick();
    end
    chk("b2b_beat_count", 64'(nbeats), 64'd27);

    // tx_en gating with two queued requests
    ifa.tx_en = 1'b0;
    drive_a(1'b1, 16'hD004, 8'h44, 16'h0400);
    tick();
    drive_a(1'b1, 16'hE005, 8'h55, 16'h0500);
    tick();
    drive_a(1'b0, 16'h0, 8'h0, 16'h0);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("gate_off_valid%0d", n), 64'(ifa.tx_valid), 64'h0);
      chk($sformatf("gate_off_busy%0d", n),  64'(ifa.busy),     64'h0);
      tick();
    end
    ifa.tx_en = 1'b1;
    tick();
    chk("gate_first_beat",  ifa.tx_data,       beat(16'hD004, 8'h44, 16'h0400, 8'd0));
    chk("gate_first_valid", 64'(ifa.tx_valid), 64'h1);
    for (int k = 1; k < 9; k++) begin
      tick();
      chk($sformatf("gate_beat%0d", k), ifa.tx_data, beat(16'hD004, 8'h44, 16'h0400, 8'(k)));
      if (k == 2) ifa.tx_en = 1'b0;
    end
    chk("gate_last_done", 64'(ifa.burst_done), 64'h1);
    tick();
    chk("gate_after_valid", 64'(ifa.tx_valid), 64'h0);
    for (int n = 0; n < 6; n++) tick();
    chk("gate_held_valid", 64'(ifa.tx_valid), 64'h0);
    chk("gate_held_busy",  64'(ifa.busy),     64'h0);

    // Reset mid-burst at beat 4, with one more request still queued
    ifa.tx_en = 1'b1;
    tick();
    chk("rstb_beat0", ifa.tx_data, beat(16'hE005, 8'h55, 16'h0500, 8'd0));
    drive_a(1'b1, 16'hF006, 8'h66, 16'h0600);
    tick();
    drive_a(1'b0, 16'h0, 8'h0, 16'h0);
    tick();
    tick();
    tick();
    chk("rstb_beat4", ifa.tx_data, beat(16'hE005, 8'h55, 16'h0500, 8'd4));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstb_tx_valid",   64'(ifa.tx_valid),   64'h0);
    chk("rstb_tx_data",    ifa.tx_data,         64'h0);
    chk("rstb_busy",       64'(ifa.busy),       64'h0);
    chk("rstb_burst_done", 64'(ifa.burst_done), 64'h0);
    chk("rstb_req_ready",  64'(ifa.req_ready),  64'h1);
    tick();
    rst_n = 1'b1;
    nbeats = 0;
    for (int n = 0; n < 15; n++) begin
      if (ifa.tx_valid) nbeats++;
      tick();
    end
    chk("rstb_no_residual", 64'(nbeats), 64'd0);

    // Minimum parameters: BEATS=1, GAP=1
    nbeats = 0;
    last_n = -1;
    for (int n = 0; n < 14; n++) begin
      if (ifb.tx_valid) begin
        if (nbeats < 3)
          chk($sformatf("min_beat%0d", nbeats), ifb.tx_data,
              beat(job_t[nbeats], cls_t[nbeats], lead_t[nbeats], 8'd0));
        chk($sformatf("min_done%0d", nbeats), 64'(ifb.burst_done), 64'h1);
        if (nbeats > 0)
          chk($sformatf("min_spacing%0d", nbeats), 64'(n - last_n), 64'd3);
        last_n = n;
        nbeats++;
      end
      if (n < 3) drive_b(1'b1, job_t[n], cls_t[n], lead_t[n]);
      else       drive_b(1'b0, 16'h0, 8'h0, 16'h0);
      tick();
    end
    chk("min_beat_count", 64'(nbeats), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
